seq_add_mw: RTL and testbench

SEQ_ADD_MW -- requirements
Module: seq_add_mw

---
 rtl/seq_add_pkg.sv | 14 +
 rtl/seq_add_mw_if.sv | 38 +++
 rtl/RCA16.sv | 25 ++
 rtl/seq_add_mw.sv | 133 +++++++++++++
 tb/tb_seq_add_mw.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/seq_add_pkg.sv
// seq_add_pkg -- shared definitions for the multi-word sequential adder.
//   WORD_W  : width of one datapath word (one pass through the adder)
//   state_e : controller states IDLE / RUN / DONE
package seq_add_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/seq_add_mw_if.sv
// seq_add_mw_if -- request/result bundle for seq_add_mw.
//   start    : begin an addition (master -> slave)
//   a_in     : operand A, W bits (master -> slave)
//   b_in     : operand B, W bits (master -> slave)
//   cin      : carry-in (master -> slave)
//   busy     : operation in progress (slave -> master)
//   done     : one-cycle completion pulse (slave -> master)
//   sum_out  : last completed result, W+1 bits, MSB = carry (slave -> master)
//   ovf      : signed overflow of last result, only with SEQ_ADD_MW_OVF_EN
interface seq_add_mw_if #(
    parameter int NWORDS = 4
);
    import seq_add_pkg::*;

    localparam int W = WORD_W * NWORDS;

    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W:0]   sum_out;
`ifdef SEQ_ADD_MW_OVF_EN
    logic         ovf;

    modport master (output start, a_in, b_in, cin,
                    input  busy, done, sum_out, ovf);
    modport slave  (input  start, a_in, b_in, cin,
                    output busy, done, sum_out, ovf);
`else
    modport master (output start, a_in, b_in, cin,
                    input  busy, done, sum_out);
    modport slave  (input  start, a_in, b_in, cin,
                    output busy, done, sum_out);
`endif

endinterface

// File: rtl/RCA16.sv
// RCA16 -- 16-bit ripple-carry adder, the per-word datapath of seq_add_mw.
//   a_i, b_i : 16-bit addends
//   c_i      : carry-in
//   s_o      : 16-bit sum
//   c_o      : carry-out
module RCA16 (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        c_i,
    output logic [15:0] s_o,
    output logic        c_o
);

    logic [16:0] c;

    assign c[0] = c_i;

    for (genvar i = 0; i < 16; i++) begin : g_fa
        assign s_o[i]  = a_i[i] ^ b_i[i] ^ c[i];
        assign c[i+1]  = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end

    assign c_o = c[16];

endmodule

// File: rtl/seq_add_mw.sv
// seq_add_mw -- W-bit adder (W = 16*NWORDS) that processes one 16-bit word
// per clock through a single RCA16, least significant word first.
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset
//   bus    : seq_add_mw_if slave modport (start/a_in/b_in/cin in,
//            busy/done/sum_out[/ovf] out)
// Build option: SEQ_ADD_MW_OVF_EN adds the registered signed-overflow flag ovf.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; operands captured on the accepting edge
// RUN   | one word added per cycle, idx 0..NWORDS-1 (busy=1)
// DONE  | result registered in sum_out; done=1 for this single cycle
module seq_add_mw #(
    parameter int NWORDS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    seq_add_mw_if.slave bus
);
    import seq_add_pkg::*;

    localparam int W     = WORD_W * NWORDS;
    localparam int IDX_W = $clog2(NWORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    state_e           state_q,   state_d;
    logic [IDX_W-1:0] idx_q,     idx_d;
    logic             carry_q,   carry_d;
    logic [W-1:0]     a_q,       a_d;
    logic [W-1:0]     b_q,       b_d;
    logic [W-1:0]     work_q,    work_d;
    logic [W:0]       sum_q,     sum_d;
`ifdef SEQ_ADD_MW_OVF_EN
    logic             ovf_q,     ovf_d;
`endif

    logic [WORD_W-1:0] rca_a;
    logic [WORD_W-1:0] rca_b;
    logic [WORD_W-1:0] rca_s;
    logic              rca_co;

    assign rca_a = a_q[idx_q*WORD_W +: WORD_W];
    assign rca_b = b_q[idx_q*WORD_W +: WORD_W];

    RCA16 u_rca (
        .a_i (rca_a),
        .b_i (rca_b),
        .c_i (carry_q),
        .s_o (rca_s),
        .c_o (rca_co)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        work_d  = work_q;
        sum_d   = sum_q;
`ifdef SEQ_ADD_MW_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    a_d     = bus.a_in;
                    b_d     = bus.b_in;
                    carry_d = bus.cin;
                    idx_d   = '0;
                end
            end
            RUN: begin
                work_d[idx_q*WORD_W +: WORD_W] = rca_s;
                carry_d = rca_co;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    idx_d   = '0;
                    // work_d already holds the top word written this cycle,
                    // so the full result lands in sum_out in one update.
                    sum_d   = {rca_co, work_d};
`ifdef SEQ_ADD_MW_OVF_EN
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (work_d[W-1] != a_q[W-1]);
`endif
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            sum_q   <= '0;
`ifdef SEQ_ADD_MW_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            work_q  <= work_d;
            sum_q   <= sum_d;
`ifdef SEQ_ADD_MW_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.busy    = (state_q == RUN);
    assign bus.done    = (state_q == DONE);
    assign bus.sum_out = sum_q;
`ifdef SEQ_ADD_MW_OVF_EN
    assign bus.ovf     = ovf_q;
`endif

endmodule

// File: tb/tb_seq_add_mw.sv
// tb_seq_add_mw -- directed self-checking bench for seq_add_mw (NWORDS=4).
// Define SEQ_ADD_MW_OVF_EN to also exercise the overflow flag.
module tb_seq_add_mw;

    localparam int NW = 4;
    localparam int W  = 16 * NW;

    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_errors = 0;
    logic [W:0] last_sum;

    seq_add_mw_if #(.NWORDS(NW)) bus_if ();

    seq_add_mw #(.NWORDS(NW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    endfunction

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        logic [W:0] exp;
        int k;
        exp = model(a, b, c);
        bus_if.a_in  = a;
        bus_if.b_in  = b;
        bus_if.cin   = c;
        bus_if.start = 1'b1;
        step();
        bus_if.start = 1'b0;
        chk({tag, "_busy"}, 80'(bus_if.busy), 80'd1);
        chk({tag, "_hold"}, 80'(bus_if.sum_out), 80'(last_sum));
        k = 0;
        while (!bus_if.done && k < 20) begin
            step();
            k++;
        end
        chk({tag, "_lat"}, 80'(k), 80'(NW));
        chk({tag, "_sum"}, 80'(bus_if.sum_out), 80'(exp));
        last_sum = exp;
        step();
        chk({tag, "_pulse"}, 80'(bus_if.done), 80'd0);
        chk({tag, "_idle"}, 80'(bus_if.busy), 80'd0);
    endtask

    initial begin
        int k;
        int ndone;
        logic [W-1:0] ra, rb;
        logic         rc;
        logic [W:0]   rexp;

        rst_n        = 1'b0;
        bus_if.start = 1'b0;
        bus_if.a_in  = '0;
        bus_if.b_in  = '0;
        bus_if.cin   = 1'b0;
        last_sum     = '0;
        step();
        // reset must win over a simultaneous start
        bus_if.start = 1'b1;
        bus_if.a_in  = 64'h1234;
        step();
        chk("rst_busy", 80'(bus_if.busy), 80'd0);
        chk("rst_done", 80'(bus_if.done), 80'd0);
        chk("rst_sum",  80'(bus_if.sum_out), 80'd0);
`ifdef SEQ_ADD_MW_OVF_EN
        chk("rst_ovf",  80'(bus_if.ovf), 80'd0);
`endif
        bus_if.start = 1'b0;
        rst_n = 1'b1;
        step();
        chk("idle_busy", 80'(bus_if.busy), 80'd0);

        run_op("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
        chk("ripple_val", 80'(bus_if.sum_out), 80'h1_0000_0000_0000_0000);
        run_op("nocarry", 64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, 1'b0);
        chk("nocarry_val", 80'(bus_if.sum_out), 80'h0_0011_0022_0033_0044);
`ifdef SEQ_ADD_MW_OVF_EN
        chk("nocarry_ovf", 80'(bus_if.ovf), 80'd0);
`endif
        run_op("maxall", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        chk("maxall_val", 80'(bus_if.sum_out), 80'h1_FFFF_FFFF_FFFF_FFFF);
        run_op("zero", 64'h0, 64'h0, 1'b0);
        run_op("midcarry", 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0);
        chk("midcarry_val", 80'(bus_if.sum_out), 80'h0_0001_0000_0001_0000);
`ifdef SEQ_ADD_MW_OVF_EN
        run_op("ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        chk("ovf_val", 80'(bus_if.sum_out), 80'h0_8000_0000_0000_0000);
        chk("ovf_flag", 80'(bus_if.ovf), 80'd1);
        run_op("negovf", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
        chk("negovf_flag", 80'(bus_if.ovf), 80'd1);
`endif

        // start while busy: second request must be ignored
        bus_if.a_in  = 64'd1;
        bus_if.b_in  = 64'd1;
        bus_if.cin   = 1'b0;
        bus_if.start = 1'b1;
        step();
        bus_if.start = 1'b0;
        step();
        bus_if.a_in  = 64'd5;
        bus_if.b_in  = 64'd5;
        bus_if.start = 1'b1;
        step();
        bus_if.start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus_if.done) ndone++;
            step();
        end
        chk("busy_start_ndone", 80'(ndone), 80'd1);
        chk("busy_start_sum", 80'(bus_if.sum_out), 80'd2);
        last_sum = 65'd2;

        // reset in the middle of an operation
        bus_if.a_in  = 64'd3;
        bus_if.b_in  = 64'd4;
        bus_if.start = 1'b1;
        step();
        bus_if.start = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrst_busy", 80'(bus_if.busy), 80'd0);
        chk("midrst_sum",  80'(bus_if.sum_out), 80'd0);
        last_sum = '0;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus_if.done) ndone++;
            step();
        end
        chk("midrst_ndone", 80'(ndone), 80'd0);
        run_op("after_rst", 64'h0000_0000_0000_00FF, 64'h0000_0000_0000_0101, 1'b1);
        chk("after_rst_val", 80'(bus_if.sum_out), 80'h201);

        // back-to-back with start held high
        ra = {$urandom, $urandom};
        rb = {$urandom, $urandom};
        rc = 1'($urandom_range(0, 1));
        rexp = model(ra, rb, rc);
        bus_if.a_in  = ra;
        bus_if.b_in  = rb;
        bus_if.cin   = rc;
        bus_if.start = 1'b1;
        for (int i = 0; i < 200; i++) begin
            k = 0;
            do begin
                step();
                k++;
            end while (!bus_if.done && k < 20);
            chk("rnd_done", 80'(bus_if.done), 80'd1);
            chk("rnd_sum", 80'(bus_if.sum_out), 80'(rexp));
            if (i > 0) chk("rnd_period", 80'(k), 80'(NW + 2));
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rc = 1'($urandom_range(0, 1));
            rexp = model(ra, rb, rc);
            bus_if.a_in = ra;
            bus_if.b_in = rb;
            bus_if.cin  = rc;
        end
        bus_if.start = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
